// File: rtl/display_frame_rx.sv
// Serial frame receiver: synchronizes the MCU sclk/sdata/slatch lines, shifts in a frame and
// commits red/green/anode masks atomically on latch. Optional macro FRAME_CHECKSUM_EN adds a checksum byte.
module display_frame_rx #(
    parameter int FRAME_BITS  = 96,
    parameter int SYNC_STAGES = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            sclk,
    input  logic                            sdata,
    input  logic                            slatch,
    output logic [7*(FRAME_BITS/24)-1:0]    red,
    output logic [7*(FRAME_BITS/24)-1:0]    grn,
    output logic [6*(FRAME_BITS/24)-1:0]    anode,
    output logic                            frame_valid,
    output logic                            frame_err,
    output logic                            err_sticky,
    output logic                            busy
);

`ifdef FRAME_CHECKSUM_EN
    localparam int SR_BITS = FRAME_BITS + 8;
`else
    localparam int SR_BITS = FRAME_BITS;
`endif
    localparam int DIGITS = FRAME_BITS / 24;
    localparam int OFF    = SR_BITS - FRAME_BITS;
    localparam int CW     = $clog2(SR_BITS + 2);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(SR_BITS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_OVER  = 2'd2
    } state_e;

`ifdef FRAME_CHECKSUM_EN
    function automatic logic [7:0] xor_bytes(input logic [FRAME_BITS-1:0] d);
        logic [7:0] acc;
        acc = 8'h00;
        for (int j = 0; j < FRAME_BITS / 8; j++) begin
            acc = acc ^ d[8*j +: 8];
        end
        return acc;
    endfunction
`endif

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] sdata_sync_q, sdata_sync_d;
    logic [SYNC_STAGES-1:0] slatch_sync_q, slatch_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   slatch_prev_q, slatch_prev_d;
    logic [SR_BITS-1:0]     shift_q, shift_d;
    logic [CW-1:0]          count_q, count_d;
    logic [CW-1:0]          cnt_shift_s;
    state_e                 state_q, state_d;
    logic [7*DIGITS-1:0]    red_q, red_d, grn_q, grn_d;
    logic [6*DIGITS-1:0]    anode_q, anode_d;
    logic                   valid_q, valid_d, err_q, err_d, sticky_q, sticky_d, busy_q, busy_d;
    logic                   sclk_rise_s, slatch_rise_s, cks_ok_s, frame_ok_s;

    // Synchronizer chains and edge-detect history
    always_comb begin
        sclk_sync_d   = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        sdata_sync_d  = {sdata_sync_q[SYNC_STAGES-2:0], sdata};
        slatch_sync_d = {slatch_sync_q[SYNC_STAGES-2:0], slatch};
        sclk_prev_d   = sclk_sync_q[SYNC_STAGES-1];
        slatch_prev_d = slatch_sync_q[SYNC_STAGES-1];
        sclk_rise_s   = sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
        slatch_rise_s = slatch_sync_q[SYNC_STAGES-1] & ~slatch_prev_q;
    end

    // Receive FSM: tracks whether the bit count is empty, in range or overrun
    always_comb begin
        state_d = state_q;
        if (slatch_rise_s) begin
            state_d = ST_IDLE;
        end else if (sclk_rise_s) begin
            case (state_q)
                ST_IDLE:  state_d = ST_SHIFT;
                ST_SHIFT: begin
                    if (count_q == CNT_FULL) begin
                        state_d = ST_OVER;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
                ST_OVER:  state_d = ST_OVER;
                default:  state_d = ST_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Shift, count and commit; a same-cycle sclk edge is folded in before the latch check
    always_comb begin
        shift_d     = shift_q;
        cnt_shift_s = count_q;
        red_d       = red_q;
        grn_d       = grn_q;
        anode_d     = anode_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;
        sticky_d    = sticky_q;
        if (sclk_rise_s) begin
            shift_d = {shift_q[SR_BITS-2:0], sdata_sync_q[SYNC_STAGES-1]};
            if (state_q != ST_OVER) begin
                cnt_shift_s = count_q + CNT_ONE;
            end else begin
                cnt_shift_s = count_q;
            end
        end else begin
            shift_d     = shift_q;
            cnt_shift_s = count_q;
        end
`ifdef FRAME_CHECKSUM_EN
        cks_ok_s = (xor_bytes(shift_d[SR_BITS-1:8]) == shift_d[7:0]);
`else
        cks_ok_s = 1'b1;
`endif
        frame_ok_s = (cnt_shift_s == CNT_FULL) && cks_ok_s;
        count_d    = cnt_shift_s;
        if (slatch_rise_s) begin
            count_d = CNT_ZERO;
            if (frame_ok_s) begin
                // Digit 1 is the last 24 data bits shifted, i.e. the lowest data field
                for (int k = 0; k < DIGITS; k++) begin
                    red_d[7*k +: 7]   = shift_d[OFF + 24*k + 16 +: 7];
                    grn_d[7*k +: 7]   = shift_d[OFF + 24*k + 8 +: 7];
                    anode_d[6*k +: 6] = shift_d[OFF + 24*k +: 6];
                end
                valid_d  = 1'b1;
                sticky_d = 1'b0;
            end else begin
                err_d    = 1'b1;
                sticky_d = 1'b1;
            end
        end else begin
            count_d = cnt_shift_s;
        end
        busy_d = (count_d != CNT_ZERO);
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q   <= '0;
            sdata_sync_q  <= '0;
            slatch_sync_q <= '0;
            sclk_prev_q   <= 1'b0;
            slatch_prev_q <= 1'b0;
            shift_q       <= '0;
            count_q       <= CNT_ZERO;
            state_q       <= ST_IDLE;
            red_q         <= '0;
            grn_q         <= '0;
            anode_q       <= '0;
            valid_q       <= 1'b0;
            err_q         <= 1'b0;
            sticky_q      <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            sclk_sync_q   <= sclk_sync_d;
            sdata_sync_q  <= sdata_sync_d;
            slatch_sync_q <= slatch_sync_d;
            sclk_prev_q   <= sclk_prev_d;
            slatch_prev_q <= slatch_prev_d;
            shift_q       <= shift_d;
            count_q       <= count_d;
            state_q       <= state_d;
            red_q         <= red_d;
            grn_q         <= grn_d;
            anode_q       <= anode_d;
            valid_q       <= valid_d;
            err_q         <= err_d;
            sticky_q      <= sticky_d;
            busy_q        <= busy_d;
        end
    end

    assign red         = red_q;
    assign grn         = grn_q;
    assign anode       = anode_q;
    assign frame_valid = valid_q;
    assign frame_err   = err_q;
    assign err_sticky  = sticky_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_display_frame_rx.sv
// Self-checking bench for display_frame_rx: table vectors, random frames against a bit-queue
// reference model, and hand sequences for same-cycle latch, mid-frame reset and checksum.
module tb_display_frame_rx;
    localparam int FB = 96;
`ifdef FRAME_CHECKSUM_EN
    localparam int CK = 8;
`else
    localparam int CK = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sclk = 1'b0;
    logic        sdata = 1'b0;
    logic        slatch = 1'b0;
    logic [27:0] red, grn;
    logic [23:0] anode;
    logic        frame_valid, frame_err, err_sticky, busy;

    display_frame_rx dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .sdata(sdata), .slatch(slatch),
        .red(red), .grn(grn), .anode(anode), .frame_valid(frame_valid),
        .frame_err(frame_err), .err_sticky(err_sticky), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;

    // reference model: bits received since last latch, and committed state
    bit          mq[$];
    logic [27:0] m_red = 28'h0;
    logic [27:0] m_grn = 28'h0;
    logic [23:0] m_an  = 24'h0;

    typedef struct {
        int          nbits;
        logic [95:0] data;
        bit          ok;
        logic [27:0] red;
        logic [27:0] grn;
        logic [23:0] an;
    } vec_t;
    vec_t tbl[7];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] cks_of(input logic [95:0] d);
        logic [7:0] c;
        c = 8'h00;
        for (int j = 0; j < 12; j++) c = c ^ d[8*j +: 8];
        return c;
    endfunction

    task automatic send_bit(input logic b);
        sdata = b;
        repeat (2) @(negedge clk);
        sclk = 1'b1;
        repeat (4) @(negedge clk);
        sclk = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Sends nbits data bits (bits above 95 are zero) MSB first, plus checksum when enabled.
    // With hold_last, the final bit is queued in the model but left for the latch task.
    task automatic send_frame(input logic [95:0] d, input int nbits, input bit flip,
                              input bit hold_last, output logic last);
        logic [111:0] v;
        int total;
        v = '0;
        total = nbits + CK;
        for (int i = 0; i < nbits; i++) v[i + CK] = (i < 96) ? d[i] : 1'b0;
        if (CK > 0) v[7:0] = cks_of(d) ^ {7'b0, flip};
        for (int i = total - 1; i >= 0; i--) mq.push_back(v[i]);
        for (int i = total - 1; i >= (hold_last ? 1 : 0); i--) send_bit(v[i]);
        last = v[0];
    endtask

    // Model of the latch rule: exact length, checksum match, digit 1 = last 24 data bits.
    task automatic model_latch(output bit ok);
        logic [7:0] x, b, s;
        ok = (mq.size() == FB + CK);
        if (ok && CK > 0) begin
            x = 8'h00;
            for (int j = 0; j < 12; j++) begin
                b = 8'h00;
                for (int t = 0; t < 8; t++) b = {b[6:0], mq[8*j + t]};
                x = x ^ b;
            end
            s = 8'h00;
            for (int t = 0; t < 8; t++) s = {s[6:0], mq[96 + t]};
            ok = (x == s);
        end
        if (ok) begin
            for (int k = 1; k <= 4; k++) begin
                int base;
                base = FB - 24 * k;
                for (int i = 0; i < 7; i++) begin
                    m_red[7*(k-1) + i] = mq[base + 23 - (16 + i)];
                    m_grn[7*(k-1) + i] = mq[base + 23 - (8 + i)];
                end
                for (int i = 0; i < 6; i++) m_an[6*(k-1) + i] = mq[base + 23 - i];
            end
        end
        mq.delete();
    endtask

    task automatic latch_check(input string nm, input bit exp_ok, input logic [27:0] er,
                               input logic [27:0] eg, input logic [23:0] ea,
                               input bit with_bit, input logic lb);
        int vi, ei, np;
        if (with_bit) begin
            sdata = lb;
            repeat (2) @(negedge clk);
            sclk = 1'b1;
            slatch = 1'b1;
        end else begin
            @(negedge clk);
            slatch = 1'b1;
        end
        vi = 0; ei = 0; np = 0;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk);
            #1;
            if (frame_valid) begin vi = i; np++; end
            if (frame_err) begin ei = i; np++; end
        end
        check({nm, "_valid_cycle"}, vi, exp_ok ? 3 : 0);
        check({nm, "_err_cycle"}, ei, exp_ok ? 0 : 3);
        check({nm, "_pulses"}, np, 1);
        @(negedge clk);
        slatch = 1'b0;
        sclk = 1'b0;
        repeat (4) @(negedge clk);
        check({nm, "_red"}, {4'h0, red}, {4'h0, er});
        check({nm, "_grn"}, {4'h0, grn}, {4'h0, eg});
        check({nm, "_anode"}, {8'h0, anode}, {8'h0, ea});
        check({nm, "_sticky"}, {31'h0, err_sticky}, {31'h0, !exp_ok});
        check({nm, "_busy"}, {31'h0, busy}, 32'h0);
    endtask

    initial begin
        logic        lastb;
        bit          mok;
        logic [95:0] d;
        int          n;

        tbl[0] = '{96, {72'h0, 24'h7F003F}, 1'b1, 28'h000007F, 28'h0, 24'h00003F};
        tbl[1] = '{96, {96{1'b1}}, 1'b1, 28'hFFFFFFF, 28'hFFFFFFF, 24'hFFFFFF};
        tbl[2] = '{95, {72'h0, 24'h7F003F}, 1'b0, 28'hFFFFFFF, 28'hFFFFFFF, 24'hFFFFFF};
        tbl[3] = '{96, {48'h0, 24'h005500, 24'h7F003F}, 1'b1, 28'h000007F, 28'h0002A80, 24'h00003F};
        tbl[4] = '{100, {96{1'b1}}, 1'b0, 28'h000007F, 28'h0002A80, 24'h00003F};
        tbl[5] = '{96, {24'h8A80C0, 72'h0}, 1'b1, 28'h1400000, 28'h0, 24'h0};
        tbl[6] = '{0, 96'h0, 1'b0, 28'h1400000, 28'h0, 24'h0};

        // reset state
        repeat (3) @(negedge clk);
        check("rst_red", {4'h0, red}, 32'h0);
        check("rst_grn", {4'h0, grn}, 32'h0);
        check("rst_anode", {8'h0, anode}, 32'h0);
        check("rst_flags", {28'h0, frame_valid, frame_err, err_sticky, busy}, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int t = 0; t < 7; t++) begin
            if (tbl[t].nbits > 0) send_frame(tbl[t].data, tbl[t].nbits, 1'b0, 1'b0, lastb);
            if (t == 0) check("busy_after_bits", {31'h0, busy}, 32'h1);
            model_latch(mok);
            latch_check($sformatf("tbl%0d", t), tbl[t].ok, tbl[t].red, tbl[t].grn, tbl[t].an,
                        1'b0, 1'b0);
        end

        for (int r = 0; r < 10; r++) begin
            d = {$urandom, $urandom, $urandom};
            case ($urandom_range(0, 5))
                4: n = 95;
                5: n = 98;
                default: n = 96;
            endcase
            send_frame(d, n, 1'b0, 1'b0, lastb);
            model_latch(mok);
            latch_check($sformatf("rnd%0d", r), mok, m_red, m_grn, m_an, 1'b0, 1'b0);
        end

        // latch edge detected in the same cycle as the final sclk edge
        send_frame({72'h0, 24'h123415}, 96, 1'b0, 1'b1, lastb);
        model_latch(mok);
        latch_check("same_cycle", 1'b1, 28'h12, 28'h34, 24'h15, 1'b1, lastb);

        // reset in the middle of a frame
        for (int i = 0; i < 50; i++) send_bit(i[0]);
        check("mid_busy", {31'h0, busy}, 32'h1);
        rst_n = 1'b0;
        mq.delete();
        m_red = 28'h0; m_grn = 28'h0; m_an = 24'h0;
        repeat (2) @(negedge clk);
        check("midrst_outs", {4'h0, red} | {4'h0, grn} | {8'h0, anode}, 32'h0);
        check("midrst_flags", {29'h0, err_sticky, busy, frame_valid}, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        send_frame({72'h0, 24'h7F003F}, 96, 1'b0, 1'b0, lastb);
        model_latch(mok);
        latch_check("after_rst", 1'b1, 28'h7F, 28'h0, 24'h3F, 1'b0, 1'b0);

`ifdef FRAME_CHECKSUM_EN
        send_frame({72'h0, 24'h2A0C15}, 96, 1'b1, 1'b0, lastb);
        model_latch(mok);
        latch_check("cks_bad", 1'b0, 28'h7F, 28'h0, 24'h3F, 1'b0, 1'b0);
        send_frame({72'h0, 24'h2A0C15}, 96, 1'b0, 1'b0, lastb);
        model_latch(mok);
        latch_check("cks_good", 1'b1, 28'h2A, 28'h0C, 24'h15, 1'b0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
